pia_port_ctrl: RTL and testbench
================================

PIA_PORT_CTRL -- requirements
Module: pia_port_ctrl

Interface
REQ-001 clk  input  1  system clock; all state changes on its rising edge.
REQ-002 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 cs1, cs2, cs3  input  1 each  chip selects; block selected when cs1 & cs2 & ~cs3 (sel).
REQ-004 rw  input  1  1 = CPU read, 0 = CPU write.
REQ-005 rs  input  2  register select.
REQ-006 din  input  8  CPU write data, the latched output of the data input register.
REQ-007 dout  output  8  CPU read data, combinational from rs and state.
REQ-008 pa_in  input  8  peripheral pin levels.
REQ-009 pa_out, pa_oe  output  8 each  peripheral drive value and per-bit output enable.
REQ-010 ca1  input  1  interrupt/handshake input.
REQ-011 ca2_in  input  1; ca2_out, ca2_oe  output  1 each  bidirectional control line.
REQ-012 irq_n  output  1  active-low interrupt request.

Function
REQ-013 Registers: ORA (output), DDRA (1 = output bit), CRA (control). rs=00 with CRA[2]=1 selects ORA; rs=00 with CRA[2]=0 selects DDRA; rs=01 selects CRA; rs=1x reads 8'h00, writes ignored.
REQ-014 Write: on clk when sel & ~rw, selected register loads din; CRA write affects bits 5:0 only; bits 7:6 are read-only flags.
REQ-015 Read ORA: dout = (pa_in & ~DDRA) | (ORA & DDRA); DDRA and CRA read back as stored.
REQ-016 pa_out = ORA, pa_oe = DDRA, both registered.
REQ-017 Read event: on clk when sel & rw & rs=00 & CRA[2]=1; this clears CRA[7] and CRA[6] on that edge.
REQ-018 CA1 active edge: falling if CRA[1]=0, rising if CRA[1]=1; it sets CRA[7].
REQ-019 CA2 input mode (CRA[5]=0): ca2_oe=0; active edge per CRA[4] (0 falling, 1 rising) sets CRA[6].
REQ-020 CA2 output mode (CRA[5]=1): ca2_oe=1; CRA[6] held 0.
REQ-021 CRA[5:3]=100 read handshake: ca2_out goes 0 on the clock after a read event and returns to 1 on the clock after a CA1 active edge.
REQ-022 CRA[5:3]=101 pulse: ca2_out is 0 for exactly one clock following each read event, 1 otherwise.
REQ-023 CRA[5:3]=11x manual: ca2_out = CRA[3].
REQ-024 irq_n = ~((CRA[7] & CRA[0]) | (CRA[6] & CRA[3] & ~CRA[5])), registered.
REQ-025 A flag-set edge and a clearing read on the same clock leave the flag set.
REQ-026 CA1 edge and read event on the same clock in handshake mode drive ca2_out to 1.
REQ-027 Entering handshake mode via a CRA write sets ca2_out=1.

Reset
REQ-028 reset forces ORA, DDRA and CRA to 8'h00, ca2_out=1, irq_n=1, pa_oe=8'h00, pa_out=8'h00, ca2_oe=0, and clears edge-detector history; reset overrides a simultaneous write.
REQ-029 No edge is detected on the first clock after reset deasserts.

Configuration
REQ-030 PIA_SYNC_EN defined: ca1 and ca2_in pass through a two-flop synchronizer before edge detection, giving a 3-clock latency from pin edge to flag; pa_in is also two-flop synchronized before the read mux.
REQ-031 PIA_SYNC_EN undefined: edge detection acts on the raw inputs, giving a 1-clock latency from pin edge to flag; pa_in is used directly.

Structure
REQ-032 Shared package pia_pkg holds the rs encodings, the CRA bit-index constants and the CA2 mode encodings.
REQ-033 Sub-module pia_edge_det holds the optional synchronizer, previous-value register and polarity-selectable edge pulse; it is instantiated twice (ca1 and ca2_in).

Verification
REQ-034 Reset, write DDRA=8'hF0, set CRA[2], write ORA=8'hA5, pa_in=8'h3C -> pa_oe=F0, pa_out=A5, ORA read returns 8'hAC.
REQ-035 CRA=8'h07 (CA1 rising edge, irq enabled, ORA selected), ca1 0->1 -> CRA[7]=1 and irq_n=0 after the configured latency; ORA read -> CRA[7]=0 and irq_n=1 on the next clock.
REQ-036 CRA=8'h24 (handshake), ORA read -> ca2_out=0; ca1 falling edge -> ca2_out=1.
REQ-037 CRA=8'h2C (pulse), ORA read -> ca2_out low for exactly 1 clock.
REQ-038 CA1 edge coincident with an ORA read -> CRA[7] remains 1.
REQ-039 Reset asserted in handshake mode with ca2_out=0 -> all registers 0, ca2_oe=0, irq_n=1, and a CRA write of 8'hFF reads back 8'h3F.

Source files
------------

// File: rtl/pia_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pia_pkg
// Description : Shared register-select encodings, CRA bit indices, CA2 modes
//               and the interrupt-request helper for the PIA port controller.
// Revision    : 1.0 - initial release
// ============================================================================
package pia_pkg;

    localparam logic [1:0] c_RS_DATA = 2'b00;
    localparam logic [1:0] c_RS_CTRL = 2'b01;

    localparam int c_CRA_IRQA1   = 7;
    localparam int c_CRA_IRQA2   = 6;
    localparam int c_CRA_CA2_DIR = 5;
    localparam int c_CRA_CA2_POL = 4;
    localparam int c_CRA_CA2_CTL = 3;
    localparam int c_CRA_DDR_SEL = 2;
    localparam int c_CRA_CA1_POL = 1;
    localparam int c_CRA_CA1_IE  = 0;

    localparam logic [2:0] c_CA2_HANDSHAKE = 3'b100;
    localparam logic [2:0] c_CA2_PULSE     = 3'b101;

    function automatic logic cra_irq(input logic [7:0] cra);
        return (cra[c_CRA_IRQA1] & cra[c_CRA_CA1_IE]) |
               (cra[c_CRA_IRQA2] & cra[c_CRA_CA2_CTL] & ~cra[c_CRA_CA2_DIR]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pia_port_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pia_port_ctrl_if
// Description : CPU bus, peripheral port and CA1/CA2 control lines of the PIA.
// Revision    : 1.0 - initial release
// ============================================================================
interface pia_port_ctrl_if;
    logic       cs1;
    logic       cs2;
    logic       cs3;
    logic       rw;
    logic [1:0] rs;
    logic [7:0] din;
    logic [7:0] dout;
    logic [7:0] pa_in;
    logic [7:0] pa_out;
    logic [7:0] pa_oe;
    logic       ca1;
    logic       ca2_in;
    logic       ca2_out;
    logic       ca2_oe;
    logic       irq_n;

    modport master (
        output cs1, cs2, cs3, rw, rs, din, pa_in, ca1, ca2_in,
        input  dout, pa_out, pa_oe, ca2_out, ca2_oe, irq_n
    );

    modport slave (
        input  cs1, cs2, cs3, rw, rs, din, pa_in, ca1, ca2_in,
        output dout, pa_out, pa_oe, ca2_out, ca2_oe, irq_n
    );
endinterface
`default_nettype wire

// File: rtl/pia_edge_det.sv
`default_nettype none
// ============================================================================
// Module      : pia_edge_det
// Description : Optional two-flop synchronizer (PIA_SYNC_EN) followed by a
//               polarity-selectable single-cycle edge detector.
// Revision    : 1.0 - initial release
// ============================================================================
module pia_edge_det (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic i_sig,
    input  wire logic i_rise,
    output logic      o_edge
);
    logic w_sig;
    logic r_prev;
    logic r_armed;

`ifdef PIA_SYNC_EN
    logic [1:0] r_sync;

    always_ff @(posedge clk) begin
        if (reset) r_sync <= 2'b00;
        else       r_sync <= {r_sync[0], i_sig};
    end

    assign w_sig = r_sync[1];
`else
    assign w_sig = i_sig;
`endif

    // r_armed suppresses a spurious edge against the cleared history.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev  <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_prev  <= w_sig;
            r_armed <= 1'b1;
        end
    end

    assign o_edge = r_armed & (i_rise ? (w_sig & ~r_prev) : (~w_sig & r_prev));

endmodule
`default_nettype wire

// File: rtl/pia_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pia_port_ctrl
// Description : One PIA peripheral port (ORA/DDRA/CRA) with CA1/CA2 control.
//               Define PIA_SYNC_EN to synchronize ca1, ca2_in and pa_in.
// Revision    : 1.0 - initial release
// ============================================================================
module pia_port_ctrl
    import pia_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       reset,
    pia_port_ctrl_if.slave  bus
);
    logic [7:0] r_ora;
    logic [7:0] r_ddra;
    logic [7:0] r_cra;
    logic       r_ca2_out;
    logic       r_irq_n;
    logic [7:0] w_cra_nxt;
    logic       w_ca2_nxt;
    logic [7:0] w_pa;
    logic       w_sel, w_wr, w_rd_evt;
    logic       w_wr_ora, w_wr_ddra, w_wr_cra;
    logic       w_ca1_edge, w_ca2_edge;

    assign w_sel     = bus.cs1 & bus.cs2 & ~bus.cs3;
    assign w_wr      = w_sel & ~bus.rw;
    assign w_rd_evt  = w_sel & bus.rw & (bus.rs == c_RS_DATA) & r_cra[c_CRA_DDR_SEL];
    assign w_wr_ora  = w_wr & (bus.rs == c_RS_DATA) &  r_cra[c_CRA_DDR_SEL];
    assign w_wr_ddra = w_wr & (bus.rs == c_RS_DATA) & ~r_cra[c_CRA_DDR_SEL];
    assign w_wr_cra  = w_wr & (bus.rs == c_RS_CTRL);

`ifdef PIA_SYNC_EN
    logic [7:0] r_pa_s1;
    logic [7:0] r_pa_s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pa_s1 <= 8'h00;
            r_pa_s2 <= 8'h00;
        end else begin
            r_pa_s1 <= bus.pa_in;
            r_pa_s2 <= r_pa_s1;
        end
    end

    assign w_pa = r_pa_s2;
`else
    assign w_pa = bus.pa_in;
`endif

    pia_edge_det u_ca1_det (
        .clk    (clk),
        .reset  (reset),
        .i_sig  (bus.ca1),
        .i_rise (r_cra[c_CRA_CA1_POL]),
        .o_edge (w_ca1_edge)
    );

    pia_edge_det u_ca2_det (
        .clk    (clk),
        .reset  (reset),
        .i_sig  (bus.ca2_in),
        .i_rise (r_cra[c_CRA_CA2_POL]),
        .o_edge (w_ca2_edge)
    );

    // Flag-setting edges take priority over the clearing read.
    always_comb begin
        w_cra_nxt = r_cra;
        if (w_wr_cra) w_cra_nxt[5:0] = bus.din[5:0];
        if (w_ca1_edge)    w_cra_nxt[c_CRA_IRQA1] = 1'b1;
        else if (w_rd_evt) w_cra_nxt[c_CRA_IRQA1] = 1'b0;
        if (w_cra_nxt[c_CRA_CA2_DIR]) w_cra_nxt[c_CRA_IRQA2] = 1'b0;
        else if (w_ca2_edge)          w_cra_nxt[c_CRA_IRQA2] = 1'b1;
        else if (w_rd_evt)            w_cra_nxt[c_CRA_IRQA2] = 1'b0;
    end

    always_comb begin
        w_ca2_nxt = r_ca2_out;
        if (w_wr_cra) begin
            w_ca2_nxt = (bus.din[5:4] == 2'b11) ? bus.din[3] : 1'b1;
        end else begin
            case (r_cra[5:3])
                c_CA2_HANDSHAKE: begin
                    if (w_ca1_edge)    w_ca2_nxt = 1'b1;
                    else if (w_rd_evt) w_ca2_nxt = 1'b0;
                end
                c_CA2_PULSE: w_ca2_nxt = ~w_rd_evt;
                default:     w_ca2_nxt = r_cra[c_CRA_CA2_DIR] ? r_cra[c_CRA_CA2_CTL] : 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ora     <= 8'h00;
            r_ddra    <= 8'h00;
            r_cra     <= 8'h00;
            r_ca2_out <= 1'b1;
            r_irq_n   <= 1'b1;
        end else begin
            if (w_wr_ora)  r_ora  <= bus.din;
            if (w_wr_ddra) r_ddra <= bus.din;
            r_cra     <= w_cra_nxt;
            r_ca2_out <= w_ca2_nxt;
            r_irq_n   <= ~cra_irq(w_cra_nxt);
        end
    end

    always_comb begin
        case (bus.rs)
            c_RS_DATA: bus.dout = r_cra[c_CRA_DDR_SEL] ? ((w_pa & ~r_ddra) | (r_ora & r_ddra))
                                                       : r_ddra;
            c_RS_CTRL: bus.dout = r_cra;
            default:   bus.dout = 8'h00;
        endcase
    end

    assign bus.pa_out  = r_ora;
    assign bus.pa_oe   = r_ddra;
    assign bus.ca2_out = r_ca2_out;
    assign bus.ca2_oe  = r_cra[c_CRA_CA2_DIR];
    assign bus.irq_n   = r_irq_n;

endmodule
`default_nettype wire

// File: tb/tb_pia_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pia_port_ctrl
// Description : Directed self-checking bench for pia_port_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pia_port_ctrl;
`ifdef PIA_SYNC_EN
    localparam int c_LAT = 3;
`else
    localparam int c_LAT = 1;
`endif

    logic clk;
    logic reset;
    int   n_chk;
    int   n_err;
    logic [7:0] v;

    pia_port_ctrl_if bus ();

    pia_port_ctrl u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.cs1 = 1'b0; bus.cs2 = 1'b0; bus.cs3 = 1'b0;
        bus.rw  = 1'b1; bus.rs  = 2'b00; bus.din = 8'h00;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        bus.cs1 = 1'b1; bus.cs2 = 1'b1; bus.cs3 = 1'b0;
        bus.rw  = 1'b0; bus.rs  = a;    bus.din = d;
        cyc();
        idle();
    endtask

    task automatic rd(input logic [1:0] a, output logic [7:0] d);
        bus.cs1 = 1'b1; bus.cs2 = 1'b1; bus.cs3 = 1'b0;
        bus.rw  = 1'b1; bus.rs  = a;
        #1 d = bus.dout;
        cyc();
        idle();
    endtask

    task automatic peek(input logic [1:0] a, output logic [7:0] d);
        bus.rs = a;
        #1 d = bus.dout;
        bus.rs = 2'b00;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        idle();
        bus.pa_in = 8'h00; bus.ca1 = 1'b0; bus.ca2_in = 1'b1;
        reset = 1'b1;
        // write of 8'hFF to CRA held during reset must be ignored
        bus.cs1 = 1'b1; bus.cs2 = 1'b1; bus.rw = 1'b0; bus.rs = 2'b01; bus.din = 8'hFF;
        repeat (3) cyc();
        reset = 1'b0;
        idle();
        peek(2'b01, v); chk("rst_cra", v, 8'h00);
        peek(2'b00, v); chk("rst_ddra", v, 8'h00);
        chk("rst_pa_out", bus.pa_out, 8'h00);
        chk("rst_pa_oe", bus.pa_oe, 8'h00);
        chk("rst_ca2_out", {7'd0, bus.ca2_out}, 8'h01);
        chk("rst_ca2_oe", {7'd0, bus.ca2_oe}, 8'h00);
        chk("rst_irq_n", {7'd0, bus.irq_n}, 8'h01);

        // Port data path
        wr(2'b00, 8'hF0);
        peek(2'b00, v); chk("ddra_rb", v, 8'hF0);
        wr(2'b01, 8'h04);
        wr(2'b00, 8'hA5);
        bus.pa_in = 8'h3C;
        repeat (3) cyc();
        chk("pa_oe", bus.pa_oe, 8'hF0);
        chk("pa_out", bus.pa_out, 8'hA5);
        rd(2'b00, v); chk("ora_read", v, 8'hAC);
        wr(2'b10, 8'h55);
        peek(2'b10, v); chk("rs10_read", v, 8'h00);
        chk("rs10_no_write", bus.pa_out, 8'hA5);

        // CA1 rising edge interrupt
        wr(2'b01, 8'h07);
        peek(2'b01, v); chk("cra_07", v, 8'h07);
        bus.ca1 = 1'b1;
        for (int i = 0; i < c_LAT - 1; i++) begin
            cyc();
            peek(2'b01, v); chk("ca1_latency", v, 8'h07);
        end
        cyc();
        peek(2'b01, v); chk("ca1_flag", v, 8'h87);
        chk("ca1_irq_n", {7'd0, bus.irq_n}, 8'h00);
        rd(2'b00, v);
        peek(2'b01, v); chk("ca1_clear", v, 8'h07);
        chk("ca1_irq_clr", {7'd0, bus.irq_n}, 8'h01);

        // CA1 edge coincident with the clearing read
        bus.ca1 = 1'b0;
        repeat (c_LAT + 1) cyc();
        peek(2'b01, v); chk("ca1_fall_ignored", v, 8'h07);
        bus.ca1 = 1'b1;
        repeat (c_LAT - 1) cyc();
        rd(2'b00, v);
        peek(2'b01, v); chk("coincide_flag", v, 8'h87);
        chk("coincide_irq_n", {7'd0, bus.irq_n}, 8'h00);
        rd(2'b00, v);

        // Read handshake on CA2
        wr(2'b01, 8'h24);
        chk("hs_entry", {7'd0, bus.ca2_out}, 8'h01);
        chk("hs_oe", {7'd0, bus.ca2_oe}, 8'h01);
        rd(2'b00, v);
        chk("hs_low", {7'd0, bus.ca2_out}, 8'h00);
        cyc();
        chk("hs_hold", {7'd0, bus.ca2_out}, 8'h00);
        bus.ca1 = 1'b0;
        repeat (c_LAT - 1) cyc();
        chk("hs_wait", {7'd0, bus.ca2_out}, 8'h00);
        cyc();
        chk("hs_release", {7'd0, bus.ca2_out}, 8'h01);
        peek(2'b01, v); chk("hs_flag", v, 8'hA4);
        chk("hs_irq_off", {7'd0, bus.irq_n}, 8'h01);
        bus.ca1 = 1'b1;
        repeat (c_LAT + 1) cyc();
        bus.ca1 = 1'b0;
        repeat (c_LAT - 1) cyc();
        rd(2'b00, v);
        chk("hs_coincide", {7'd0, bus.ca2_out}, 8'h01);

        // Pulse mode
        wr(2'b01, 8'h2C);
        chk("pulse_idle", {7'd0, bus.ca2_out}, 8'h01);
        rd(2'b00, v);
        chk("pulse_low", {7'd0, bus.ca2_out}, 8'h00);
        cyc();
        chk("pulse_high", {7'd0, bus.ca2_out}, 8'h01);
        cyc();
        chk("pulse_stay", {7'd0, bus.ca2_out}, 8'h01);

        // CA2 input, falling edge, irq enabled
        wr(2'b01, 8'h0C);
        chk("ca2_in_oe", {7'd0, bus.ca2_oe}, 8'h00);
        bus.ca2_in = 1'b0;
        repeat (c_LAT) cyc();
        peek(2'b01, v); chk("ca2_flag", v, 8'h4C);
        chk("ca2_irq_n", {7'd0, bus.irq_n}, 8'h00);
        rd(2'b00, v);
        peek(2'b01, v); chk("ca2_clear", v, 8'h0C);
        chk("ca2_irq_clr", {7'd0, bus.irq_n}, 8'h01);

        // Manual CA2
        wr(2'b01, 8'h38);
        chk("man_hi", {7'd0, bus.ca2_out}, 8'h01);
        wr(2'b01, 8'h30);
        chk("man_lo", {7'd0, bus.ca2_out}, 8'h00);

        // Reset in the middle of a handshake
        wr(2'b01, 8'h24);
        rd(2'b00, v);
        chk("pre_rst_low", {7'd0, bus.ca2_out}, 8'h00);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        peek(2'b01, v); chk("rst2_cra", v, 8'h00);
        peek(2'b00, v); chk("rst2_ddra", v, 8'h00);
        chk("rst2_pa_out", bus.pa_out, 8'h00);
        chk("rst2_ca2_oe", {7'd0, bus.ca2_oe}, 8'h00);
        chk("rst2_ca2_out", {7'd0, bus.ca2_out}, 8'h01);
        chk("rst2_irq_n", {7'd0, bus.irq_n}, 8'h01);
        wr(2'b01, 8'hFF);
        peek(2'b01, v); chk("cra_ff_rb", v, 8'h3F);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
